// File: rtl/inertial_integrator_cal.sv
// -----------------------------------------------------------------------------
// inertial_integrator_cal
//
// Integrates offset-compensated pitch rate and nudges the integrator toward
// the accelerometer-derived pitch on every valid sample. A small CAL/RUN
// state machine learns the rate and AZ offsets by averaging 2^CAL_LOG2
// samples; cal_start re-enters calibration at any time.
//
// Optional feature (compile-time macro): INERT_INT_SAT_EN
//   defined   : the integrator saturates instead of wrapping, and sat is a
//               sticky flag that is cleared by rst or cal_start
//   undefined : the integrator wraps modulo 2^INT_W and sat is tied low
//
// Ports:
//   clk        in   system clock
//   rst        in   synchronous active-high reset (highest priority)
//   vld        in   one-cycle strobe, new ptch_rt/AZ sample
//   ptch_rt    in   [DATA_W] signed raw pitch rate
//   AZ         in   [DATA_W] signed raw Z acceleration
//   cal_start  in   one-cycle request to (re)calibrate
//   ptch       out  [DATA_W] signed fused pitch (integer part of integrator)
//   cal_done   out  high while running with valid offsets
//   sat        out  sticky integrator-saturation flag
// -----------------------------------------------------------------------------
module inertial_integrator_cal #(
  parameter int                DATA_W          = 16,
  parameter int                INT_FRAC        = 11,
  parameter int                CAL_LOG2        = 8,
  parameter logic [DATA_W-1:0] PTCH_RT_OFS_DEF = 16'h0050,
  parameter logic [DATA_W-1:0] AZ_OFS_DEF      = 16'h00A0,
  parameter int                FUDGE           = 327,
  parameter int                ACC_SHIFT       = 13,
  parameter int                FUSION_STEP     = 1024,
  parameter int                AUTO_CAL        = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vld,
  input  logic [DATA_W-1:0] ptch_rt,
  input  logic [DATA_W-1:0] AZ,
  input  logic              cal_start,
  output logic [DATA_W-1:0] ptch,
  output logic              cal_done,
  output logic              sat
);

  localparam int INT_W  = DATA_W + INT_FRAC;
  localparam int ACC_W  = DATA_W + CAL_LOG2;
  localparam int CNT_W  = CAL_LOG2 + 1;
  // FUDGE is below 1024, so 11 extra bits hold the signed product.
  localparam int PROD_W = DATA_W + 11;

  localparam logic [CNT_W-1:0]        CNT_LAST = CNT_W'((1 << CAL_LOG2) - 1);
  localparam logic signed [INT_W-1:0] F_POS    = INT_W'(FUSION_STEP);
  localparam logic signed [INT_W-1:0] F_NEG    = -F_POS;

  typedef enum logic {ST_CAL, ST_RUN} state_t;

  state_t                     state_q, state_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic signed [ACC_W-1:0]    acc_rt_q, acc_rt_d;
  logic signed [ACC_W-1:0]    acc_az_q, acc_az_d;
  logic signed [DATA_W-1:0]   rate_ofs_q, rate_ofs_d;
  logic signed [DATA_W-1:0]   az_ofs_q, az_ofs_d;
  logic signed [INT_W-1:0]    ptch_int_q, ptch_int_d;
  logic                       cal_done_q, cal_done_d;

  // Datapath intermediates
  logic signed [ACC_W-1:0]    acc_rt_sum, acc_az_sum;
  logic signed [DATA_W-1:0]   rt_comp, az_comp, ptch_acc;
  logic signed [PROD_W-1:0]   az_ext, fudge_ext, prod;
  logic signed [INT_W-1:0]    f_val;
  logic signed [INT_W-1:0]    int_next;

`ifdef INERT_INT_SAT_EN
  localparam logic signed [INT_W+1:0] INT_MAX_W = (INT_W+2)'((64'sd1 <<< (INT_W-1)) - 64'sd1);
  localparam logic signed [INT_W+1:0] INT_MIN_W = -INT_MAX_W - (INT_W+2)'(1);
  logic                       sat_q, sat_d;
  logic signed [INT_W+1:0]    int_wide;
  logic                       clamp;
`endif

  always_comb begin
    // Accumulators grow by the sign-extended raw sample during calibration.
    acc_rt_sum = acc_rt_q + ACC_W'(signed'(ptch_rt));
    acc_az_sum = acc_az_q + ACC_W'(signed'(AZ));

    rt_comp = signed'(ptch_rt) - rate_ofs_q;
    az_comp = signed'(AZ) - az_ofs_q;

    az_ext    = PROD_W'(az_comp);
    fudge_ext = PROD_W'(FUDGE);
    prod      = az_ext * fudge_ext;
    ptch_acc  = DATA_W'(prod >>> ACC_SHIFT);

    if (ptch_acc > rt_comp) begin
      f_val = F_POS;
    end else if (ptch_acc < rt_comp) begin
      f_val = F_NEG;
    end else begin
      f_val = '0;
    end

`ifdef INERT_INT_SAT_EN
    // Evaluate in two extra bits so an overflow is visible before clamping.
    int_wide = (INT_W+2)'(ptch_int_q) - (INT_W+2)'(rt_comp) + (INT_W+2)'(f_val);
    clamp    = 1'b0;
    if (int_wide > INT_MAX_W) begin
      int_next = INT_MAX_W[INT_W-1:0];
      clamp    = 1'b1;
    end else if (int_wide < INT_MIN_W) begin
      int_next = INT_MIN_W[INT_W-1:0];
      clamp    = 1'b1;
    end else begin
      int_next = int_wide[INT_W-1:0];
    end
`else
    int_next = ptch_int_q - INT_W'(rt_comp) + f_val;
`endif

    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_rt_d   = acc_rt_q;
    acc_az_d   = acc_az_q;
    rate_ofs_d = rate_ofs_q;
    az_ofs_d   = az_ofs_q;
    ptch_int_d = ptch_int_q;
    cal_done_d = cal_done_q;
`ifdef INERT_INT_SAT_EN
    sat_d      = sat_q;
`endif

    if (cal_start) begin
      // Restart wins over a coincident sample; offsets stay until the new
      // calibration completes.
      state_d    = ST_CAL;
      cnt_d      = '0;
      acc_rt_d   = '0;
      acc_az_d   = '0;
      ptch_int_d = '0;
      cal_done_d = 1'b0;
`ifdef INERT_INT_SAT_EN
      sat_d      = 1'b0;
`endif
    end else if (vld) begin
      case (state_q)
        ST_CAL: begin
          acc_rt_d   = acc_rt_sum;
          acc_az_d   = acc_az_sum;
          cnt_d      = cnt_q + CNT_W'(1);
          ptch_int_d = '0;
          if (cnt_q == CNT_LAST) begin
            // Arithmetic shift gives the mean rounded toward -inf.
            rate_ofs_d = DATA_W'(acc_rt_sum >>> CAL_LOG2);
            az_ofs_d   = DATA_W'(acc_az_sum >>> CAL_LOG2);
            state_d    = ST_RUN;
            cal_done_d = 1'b1;
          end
        end
        default: begin
          ptch_int_d = int_next;
`ifdef INERT_INT_SAT_EN
          if (clamp) begin
            sat_d = 1'b1;
          end
`endif
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= (AUTO_CAL != 0) ? ST_CAL : ST_RUN;
      cnt_q      <= '0;
      acc_rt_q   <= '0;
      acc_az_q   <= '0;
      rate_ofs_q <= PTCH_RT_OFS_DEF;
      az_ofs_q   <= AZ_OFS_DEF;
      ptch_int_q <= '0;
      cal_done_q <= (AUTO_CAL != 0) ? 1'b0 : 1'b1;
`ifdef INERT_INT_SAT_EN
      sat_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_rt_q   <= acc_rt_d;
      acc_az_q   <= acc_az_d;
      rate_ofs_q <= rate_ofs_d;
      az_ofs_q   <= az_ofs_d;
      ptch_int_q <= ptch_int_d;
      cal_done_q <= cal_done_d;
`ifdef INERT_INT_SAT_EN
      sat_q      <= sat_d;
`endif
    end
  end

  assign ptch     = ptch_int_q[INT_W-1:INT_FRAC];
  assign cal_done = cal_done_q;
`ifdef INERT_INT_SAT_EN
  assign sat      = sat_q;
`else
  assign sat      = 1'b0;
`endif

endmodule

// File: tb/tb_inertial_integrator_cal.sv
// -----------------------------------------------------------------------------
// tb_inertial_integrator_cal
//
// Directed and randomized stimulus against an arithmetic reference model of
// the pitch integrator (AUTO_CAL=1 instance), plus a short directed check of
// an AUTO_CAL=0 instance. Honours INERT_INT_SAT_EN when defined.
// -----------------------------------------------------------------------------
module tb_inertial_integrator_cal;

  localparam int    N_CAL    = 256;
  localparam int    FUDGE_M  = 327;
  localparam int    SHIFT_M  = 13;
  localparam int    STEP_M   = 1024;
  localparam int    FRAC_M   = 11;
  localparam int    INTW_M   = 27;
  localparam longint INT_MAX_M = (64'sd1 <<< (INTW_M - 1)) - 1;
  localparam longint INT_MIN_M = -(64'sd1 <<< (INTW_M - 1));

  logic        clk = 1'b0;
  logic        rst = 1'b1, vld = 1'b0, cal_start = 1'b0;
  logic [15:0] ptch_rt = '0, az = '0;
  logic [15:0] ptch;
  logic        cal_done, sat;

  logic        rst0 = 1'b1, vld0 = 1'b0, cal_start0 = 1'b0;
  logic [15:0] ptch_rt0 = '0, az0 = '0;
  logic [15:0] ptch0;
  logic        cal_done0, sat0;

  int errors = 0;
  int checks = 0;
  int step_no = 0;

  // Reference model state
  bit     m_cal;
  int     m_cnt;
  longint m_sum_rt, m_sum_az;
  longint m_rofs, m_aofs;
  longint m_int;
  bit     m_sat;

  always #5 clk = ~clk;

  inertial_integrator_cal #(.AUTO_CAL(1)) dut (
    .clk(clk), .rst(rst), .vld(vld), .ptch_rt(ptch_rt), .AZ(az),
    .cal_start(cal_start), .ptch(ptch), .cal_done(cal_done), .sat(sat)
  );

  inertial_integrator_cal #(.AUTO_CAL(0)) dut0 (
    .clk(clk), .rst(rst0), .vld(vld0), .ptch_rt(ptch_rt0), .AZ(az0),
    .cal_start(cal_start0), .ptch(ptch0), .cal_done(cal_done0), .sat(sat0)
  );

  function automatic longint wrap(input longint x, input int w);
    longint m, r;
    m = 64'sd1 <<< w;
    r = x % m;
    if (r < 0) r = r + m;
    if (r >= m / 2) r = r - m;
    return r;
  endfunction

  function automatic longint floordiv(input longint a, input longint n);
    longint q;
    q = a / n;
    if ((a % n != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  task automatic model_reset();
    m_cal = 1'b1; m_cnt = 0; m_sum_rt = 0; m_sum_az = 0;
    m_rofs = 'h50; m_aofs = 'hA0; m_int = 0; m_sat = 1'b0;
  endtask

  task automatic model_update(input bit r, input bit v, input bit cs,
                              input logic [15:0] rt, input logic [15:0] a);
    longint srt, saz, rc, ac, pa, f, nx;
    srt = longint'($signed(rt));
    saz = longint'($signed(a));
    if (r) begin
      model_reset();
    end else if (cs) begin
      m_cal = 1'b1; m_cnt = 0; m_sum_rt = 0; m_sum_az = 0; m_int = 0; m_sat = 1'b0;
    end else if (v) begin
      if (m_cal) begin
        m_sum_rt += srt;
        m_sum_az += saz;
        m_cnt++;
        if (m_cnt == N_CAL) begin
          m_rofs = wrap(floordiv(m_sum_rt, N_CAL), 16);
          m_aofs = wrap(floordiv(m_sum_az, N_CAL), 16);
          m_cal  = 1'b0;
          m_int  = 0;
        end
      end else begin
        rc = wrap(srt - m_rofs, 16);
        ac = wrap(saz - m_aofs, 16);
        pa = wrap(floordiv(ac * FUDGE_M, 64'sd1 <<< SHIFT_M), 16);
        f  = (pa > rc) ? STEP_M : ((pa < rc) ? -STEP_M : 0);
        nx = m_int - rc + f;
`ifdef INERT_INT_SAT_EN
        if (nx > INT_MAX_M) begin
          nx = INT_MAX_M; m_sat = 1'b1;
        end else if (nx < INT_MIN_M) begin
          nx = INT_MIN_M; m_sat = 1'b1;
        end
        m_int = nx;
`else
        m_int = wrap(nx, INTW_M);
`endif
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h (step %0d)", tag, obs, exp, step_no);
    end
  endtask

  // One transaction: drive at negedge, model on posedge, sample 1ns later.
  task automatic step(input bit r, input bit v, input bit cs,
                      input logic [15:0] rt, input logic [15:0] a);
    logic [15:0] exp_ptch;
    @(negedge clk);
    rst = r; vld = v; cal_start = cs; ptch_rt = rt; az = a;
    @(posedge clk);
    model_update(r, v, cs, rt, a);
    #1;
    step_no++;
    exp_ptch = 16'(wrap(floordiv(m_int, 64'sd1 <<< FRAC_M), 16));
    $display("step %0d rst=%b vld=%b cs=%b rt=%h az=%h -> ptch=%h done=%b sat=%b",
             step_no, r, v, cs, rt, a, ptch, cal_done, sat);
    chk("ptch", 32'(ptch), 32'(exp_ptch));
    chk("cal_done", 32'(cal_done), 32'(!m_cal));
    chk("sat", 32'(sat), 32'(m_sat));
  endtask

  initial begin
    logic [15:0] r16, a16;
    model_reset();

    // AUTO_CAL=0 instance: runs straight out of reset with default offsets.
    @(negedge clk); rst0 = 1'b1;
    @(negedge clk); rst0 = 1'b0;
    chk("dut0 reset cal_done", 32'(cal_done0), 32'd1);
    chk("dut0 reset ptch", 32'(ptch0), 32'd0);
    vld0 = 1'b1; ptch_rt0 = 16'h0050; az0 = 16'h00A0;
    @(negedge clk); vld0 = 1'b0;
    chk("dut0 zero-comp ptch", 32'(ptch0), 32'd0);
    vld0 = 1'b1; ptch_rt0 = 16'h0850;
    @(negedge clk); vld0 = 1'b0;
    chk("dut0 first run ptch", 32'(ptch0), 32'h0000FFFE);
    chk("dut0 sat", 32'(sat0), 32'd0);

    // Reset, then calibrate with the default offset values.
    step(1'b1, 1'b0, 1'b0, '0, '0);
    step(1'b0, 1'b0, 1'b0, '0, '0);
    for (int i = 0; i < N_CAL; i++) step(1'b0, 1'b1, 1'b0, 16'h0050, 16'h00A0);
    chk("cal_done after cal", 32'(cal_done), 32'd1);

    // Two compensated samples of +2048 rate.
    step(1'b0, 1'b1, 1'b0, 16'h0850, 16'h00A0);
    chk("run ptch #1", 32'(ptch), 32'h0000FFFE);
    step(1'b0, 1'b1, 1'b0, 16'h0850, 16'h00A0);
    chk("run ptch #2", 32'(ptch), 32'h0000FFFD);
    step(1'b0, 1'b0, 1'b0, 16'h7777, 16'h1234);

    // cal_start with vld: sample discarded, integrator cleared.
    step(1'b0, 1'b1, 1'b1, 16'h7000, 16'h7000);
    chk("cal_start ptch", 32'(ptch), 32'd0);
    chk("cal_start cal_done", 32'(cal_done), 32'd0);

    // 100 samples then rst with vld: everything restarts from defaults.
    for (int i = 0; i < 100; i++) step(1'b0, 1'b1, 1'b0, 16'h1234, 16'h0300);
    step(1'b1, 1'b1, 1'b0, 16'h1234, 16'h0300);
    for (int i = 0; i < N_CAL; i++) step(1'b0, 1'b1, 1'b0, 16'h0100, 16'hFF00);
    for (int i = 0; i < 200; i++) begin
      r16 = 16'(32'h0100 + $urandom_range(6000) - 3000);
      a16 = 16'($urandom);
      step(1'b0, 1'($urandom_range(1)), 1'b0, r16, a16);
    end

    // Random calibration (negative sums exercise floor rounding), then run.
    step(1'b0, 1'b0, 1'b1, '0, '0);
    for (int i = 0; i < 1200 && m_cal; i++)
      step(1'b0, 1'($urandom_range(1)), 1'b0, 16'($urandom), 16'($urandom));
    for (int i = 0; i < 300; i++) begin
      r16 = 16'(m_rofs + $urandom_range(8000) - 4000);
      a16 = 16'($urandom);
      step(1'b0, 1'($urandom_range(1)), 1'b0, r16, a16);
    end

    // Saturation / wrap boundary: offsets 0, rate -32768 repeatedly.
    step(1'b0, 1'b0, 1'b1, '0, '0);
    for (int i = 0; i < N_CAL; i++) step(1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000);
    for (int i = 0; i < 1985; i++) step(1'b0, 1'b1, 1'b0, 16'h8000, 16'h0000);
    chk("pre-boundary ptch", 32'(ptch), 32'h00007FF0);
    step(1'b0, 1'b1, 1'b0, 16'h8000, 16'h0000);
`ifdef INERT_INT_SAT_EN
    chk("boundary ptch clamp", 32'(ptch), 32'h00007FFF);
    chk("boundary sat", 32'(sat), 32'd1);
`else
    chk("boundary ptch wrap", 32'(ptch), 32'h00008001);
    chk("boundary sat", 32'(sat), 32'd0);
`endif
    step(1'b0, 1'b1, 1'b0, 16'h8000, 16'h0000);

    // Idle cal_start clears sat and cal_done.
    step(1'b0, 1'b0, 1'b1, '0, '0);
    chk("idle cal_start sat", 32'(sat), 32'd0);
    chk("idle cal_start cal_done", 32'(cal_done), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/inertial_integrator_cal.md
Name: inertial_integrator_cal

Overview:
Parametrised successor to the team's pitch integrator. Integrates offset-compensated pitch rate and fuses the accelerometer-derived pitch, as before. Adds a calibration state machine that learns the rate and AZ offsets by averaging 2^CAL_LOG2 samples, plus parametrised widths and fusion constants. Sits between the inertial sensor interface and the balance controller; ptch feeds the PID.

Parameters:
DATA_W, 16, width of ptch_rt, AZ, ptch and offsets (signed)
INT_FRAC, 11, fractional bits of integrator; INT_W = DATA_W+INT_FRAC
CAL_LOG2, 8, log2 of calibration sample count (1..12)
PTCH_RT_OFS_DEF, 16'h0050, rate offset used after reset when AUTO_CAL=0
AZ_OFS_DEF, 16'h00A0, AZ offset used after reset when AUTO_CAL=0
FUDGE, 327, AZ-to-pitch gain (unsigned, <1024)
ACC_SHIFT, 13, arithmetic right shift applied to AZ_comp*FUDGE
FUSION_STEP, 1024, integrator nudge per vld toward ptch_acc
AUTO_CAL, 1, 1: reset enters CAL; 0: reset enters RUN with default offsets

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
vld  in  1  one-cycle strobe, new ptch_rt/AZ valid
ptch_rt  in  DATA_W  signed raw pitch rate
AZ  in  DATA_W  signed raw Z acceleration
cal_start  in  1  one-cycle request to (re)calibrate
ptch  out  DATA_W  signed fused pitch = ptch_int[INT_W-1:INT_FRAC]
cal_done  out  1  high while in RUN with valid offsets
sat  out  1  sticky integrator-saturation flag (see Optional Feature)

Behaviour:
- One clock, synchronous active-high reset; clk/rst only. rst has priority over every other input.
- Reset: ptch_int=0 (ptch=0), sat=0, sample count=0, accumulators=0, offsets=PTCH_RT_OFS_DEF/AZ_OFS_DEF; state=CAL, cal_done=0 if AUTO_CAL=1, else state=RUN, cal_done=1.
- States: CAL, RUN.
- CAL: each vld adds sign-extended ptch_rt and AZ into accumulators of DATA_W+CAL_LOG2 bits, count++. ptch_int held at 0.
- CAL exit: on the vld that makes count=2^CAL_LOG2, the next cycle has offsets = accumulators >>> CAL_LOG2 (arithmetic, truncation toward -inf), ptch_int=0, state=RUN, cal_done=1.
- RUN: on vld:
  - ptch_rt_comp = ptch_rt - rate_ofs, AZ_comp = AZ - az_ofs (DATA_W, wrap).
  - ptch_acc = (AZ_comp*FUDGE) >>> ACC_SHIFT, truncated to DATA_W.
  - f = +FUSION_STEP if ptch_acc > ptch_rt_comp, -FUSION_STEP if less, 0 if equal (signed compares).
  - ptch_int <= ptch_int - sext(ptch_rt_comp) + f. No vld: hold.
- Latency: ptch reflects a sample one clk after its vld.
- cal_start in any state: next cycle state=CAL, count=0, accumulators=0, ptch_int=0, cal_done=0, sat=0; offsets keep old values until the new calibration completes.
- cal_start and vld in the same cycle: cal_start wins; that sample is discarded.
- cal_start while vld is idle: no samples are required before the restart is accepted.

Optional Feature:
Macro INERT_INT_SAT_EN.
- Defined: next ptch_int is computed in INT_W+2 bits and clamped to [-2^(INT_W-1), 2^(INT_W-1)-1]. sat is set on any clamp and stays set until rst or cal_start.
- Undefined: ptch_int wraps modulo 2^INT_W; sat is tied 0.

Test Plan:
- Reset, AUTO_CAL=1, 256 vld with ptch_rt=0x0050, AZ=0x00A0 -> cal_done=0 through the 256th vld, 1 the cycle after; offsets 0x0050/0x00A0; ptch=0.
- After test 1, 2 vld with ptch_rt=0x0850, AZ=0x00A0 (comp 2048, ptch_acc 0, f=-1024) -> ptch_int=-3072 then -6144; ptch=0xFFFE then 0xFFFD.
- Calibrate with all-zero inputs (offsets 0), then 1986 vld with ptch_rt=0x8000, AZ=0 (step +33792) -> with INT_INT_SAT_EN: ptch=0x7FFF, sat=1 at vld 1986; without it: ptch wraps negative, sat=0.
- In RUN with ptch=0xFFFD, pulse cal_start together with vld -> next cycle ptch=0, cal_done=0, count=0; the sample is not accumulated.
- Assert rst mid-CAL (count=100) together with vld -> count=0, accumulators=0, default offsets, state CAL.
- AUTO_CAL=0 -> cal_done=1 the cycle after rst; ptch_rt=0x0050, AZ=0x00A0 vld -> ptch_int unchanged at 0.
